// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, arbiter state encoding and grant-owner identifiers.
package mem_port_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;
  localparam logic GNT_ICACHE = 1'b0;
  localparam logic GNT_DCACHE = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: icache, dcache and memory-side signals of the shared NPC memory port.
interface mem_port_arbiter_if import mem_port_arbiter_pkg::*; #(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) ();
  logic [AW-1:0]     icache_raddr_i;
  logic              icache_valid_i;
  logic [MASK_W-1:0] icache_rmask_i;
  logic              icache_ready_o;
  logic [DW-1:0]     icache_rdata_o;
  logic [AW-1:0]     dcache_addr_i;
  logic              dcache_valid_i;
  logic              dcache_wen_i;
  logic [DW-1:0]     dcache_wdata_i;
  logic [MASK_W-1:0] dcache_wmask_i;
  logic [MASK_W-1:0] dcache_rmask_i;
  logic              dcache_ready_o;
  logic [DW-1:0]     dcache_rdata_o;
  logic [AW-1:0]     mem_addr_o;
  logic              mem_valid_o;
  logic              mem_wen_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [MASK_W-1:0] mem_wmask_o;
  logic [MASK_W-1:0] mem_rmask_o;
  logic              mem_ready_i;
  logic [DW-1:0]     mem_rdata_i;
  modport slave (
    input  icache_raddr_i, icache_valid_i, icache_rmask_i,
    input  dcache_addr_i, dcache_valid_i, dcache_wen_i, dcache_wdata_i, dcache_wmask_i, dcache_rmask_i,
    input  mem_ready_i, mem_rdata_i,
    output icache_ready_o, icache_rdata_o, dcache_ready_o, dcache_rdata_o,
    output mem_addr_o, mem_valid_o, mem_wen_o, mem_wdata_o, mem_wmask_o, mem_rmask_o
  );
  modport master (
    output icache_raddr_i, icache_valid_i, icache_rmask_i,
    output dcache_addr_i, dcache_valid_i, dcache_wen_i, dcache_wdata_i, dcache_wmask_i, dcache_rmask_i,
    output mem_ready_i, mem_rdata_i,
    input  icache_ready_o, icache_rdata_o, dcache_ready_o, dcache_rdata_o,
    input  mem_addr_o, mem_valid_o, mem_wen_o, mem_wdata_o, mem_wmask_o, mem_rmask_o
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: next-grant picker; holds the current owner while it requests, else breaks ties on last_gnt.
module mem_arb_pick import mem_port_arbiter_pkg::*; (
  input  logic       req_i,
  input  logic       req_d,
  input  logic       last_gnt,
  input  arb_state_e cur_gnt,
  output arb_state_e nxt_gnt
);
  logic hold;
  always_comb begin
    hold = (cur_gnt == ARB_GNT_I && req_i) || (cur_gnt == ARB_GNT_D && req_d);
    nxt_gnt = hold           ? cur_gnt :
              (req_i && req_d) ? ((last_gnt == GNT_ICACHE) ? ARB_GNT_D : ARB_GNT_I) :
              req_d          ? ARB_GNT_D :
              req_i          ? ARB_GNT_I : ARB_IDLE;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: locks the shared memory port to icache or dcache for a whole transaction.
// MEM_ARB_RR_EN selects round-robin tie breaking; otherwise dcache always wins ties.
module mem_port_arbiter import mem_port_arbiter_pkg::*; (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_e state_q, state_d;
  logic last_gnt;
  logic gnt_i, gnt_d;
  mem_arb_pick u_pick (
    .req_i    (bus.icache_valid_i),
    .req_d    (bus.dcache_valid_i),
    .last_gnt (last_gnt),
    .cur_gnt  (state_q),
    .nxt_gnt  (state_d)
  );
  always_ff @(posedge clk) state_q <= rst ? ARB_IDLE : state_d;
`ifdef MEM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;
  always_comb last_gnt_d = (state_d == ARB_IDLE) ? last_gnt_q :
                           (state_d == ARB_GNT_D) ? GNT_DCACHE : GNT_ICACHE;
  always_ff @(posedge clk) last_gnt_q <= rst ? GNT_ICACHE : last_gnt_d;
  assign last_gnt = last_gnt_q;
`else
  // Pretending icache was always granted last makes every tie go to dcache.
  assign last_gnt = GNT_ICACHE;
`endif
  always_comb begin
    gnt_i = state_q == ARB_GNT_I;
    gnt_d = state_q == ARB_GNT_D;
    bus.mem_valid_o    = gnt_i ? bus.icache_valid_i : gnt_d ? bus.dcache_valid_i : 1'b0;
    bus.mem_addr_o     = gnt_i ? bus.icache_raddr_i : gnt_d ? bus.dcache_addr_i : '0;
    bus.mem_wen_o      = gnt_d & bus.dcache_wen_i;
    bus.mem_wdata_o    = gnt_d ? bus.dcache_wdata_i : '0;
    bus.mem_wmask_o    = gnt_d ? bus.dcache_wmask_i : '0;
    bus.mem_rmask_o    = gnt_i ? bus.icache_rmask_i : gnt_d ? bus.dcache_rmask_i : '0;
    bus.icache_ready_o = gnt_i & bus.mem_ready_i;
    bus.dcache_ready_o = gnt_d & bus.mem_ready_i;
    bus.icache_rdata_o = (gnt_i & bus.mem_ready_i) ? bus.mem_rdata_i : '0;
    bus.dcache_rdata_o = (gnt_d & bus.mem_ready_i) ? bus.mem_rdata_i : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tie/reset cases plus randomized icache refills and dcache accesses,
// checked cycle by cycle against a transaction-level ownership model and per-master data scoreboards.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_port_arbiter_if bus ();
  mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_i[$];
  logic [63:0] exp_d[$];
  logic rdy_en = 1'b0, rdy_force = 1'b0, stray = 1'b0, rdy_rand = 1'b0;
  logic [63:0] junk = 64'h0;
  int own = 0;
  int last = 1;

  function automatic logic [63:0] fdat(logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  assign bus.mem_ready_i = rdy_en & (rdy_force | rdy_rand) & (bus.mem_valid_o | stray);
  assign bus.mem_rdata_i = bus.mem_ready_i ? fdat(bus.mem_addr_o) : junk;

  always @(posedge clk) begin
    #1;
    rdy_rand = ($urandom % 100) < 45;
    junk = {$urandom, $urandom};
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: owner keeps the port while it requests; otherwise the requester(s) decide.
  always @(negedge clk) begin
    logic iv, dv;
    iv = bus.icache_valid_i;
    dv = bus.dcache_valid_i;
    chk("mem_valid", 64'(bus.mem_valid_o), 64'(own == 1 ? iv : own == 2 ? dv : 1'b0));
    chk("mem_addr", 64'(bus.mem_addr_o),
        64'(own == 1 ? bus.icache_raddr_i : own == 2 ? bus.dcache_addr_i : 32'h0));
    chk("mem_wen", 64'(bus.mem_wen_o), 64'(own == 2 && bus.dcache_wen_i));
    chk("mem_wdata", bus.mem_wdata_o, own == 2 ? bus.dcache_wdata_i : 64'h0);
    chk("mem_wmask", 64'(bus.mem_wmask_o), 64'(own == 2 ? bus.dcache_wmask_i : 8'h0));
    chk("mem_rmask", 64'(bus.mem_rmask_o),
        64'(own == 1 ? bus.icache_rmask_i : own == 2 ? bus.dcache_rmask_i : 8'h0));
    chk("icache_ready", 64'(bus.icache_ready_o), 64'(own == 1 && bus.mem_ready_i));
    chk("dcache_ready", 64'(bus.dcache_ready_o), 64'(own == 2 && bus.mem_ready_i));
    if (bus.icache_ready_o && exp_i.size() == 0) begin
      checks++; errors++;
      $display("FAIL icache_rdata act=%h exp=no_pending_beat t=%0t", bus.icache_rdata_o, $time);
    end else
      chk("icache_rdata", bus.icache_rdata_o, bus.icache_ready_o ? exp_i.pop_front() : 64'h0);
    if (bus.dcache_ready_o && exp_d.size() == 0) begin
      checks++; errors++;
      $display("FAIL dcache_rdata act=%h exp=no_pending_beat t=%0t", bus.dcache_rdata_o, $time);
    end else
      chk("dcache_rdata", bus.dcache_rdata_o, bus.dcache_ready_o ? exp_d.pop_front() : 64'h0);
    if (rst) begin
      own = 0;
      last = 1;
    end else if (!(own == 1 && iv) && !(own == 2 && dv)) begin
      if (iv && dv) own = (RR && last == 2) ? 1 : 2;
      else own = dv ? 2 : iv ? 1 : 0;
      if (own != 0) last = own;
    end
  end

  task automatic icache_run(int n);
    logic [31:0] a;
    bit ab, done;
    int k, cyc;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFF0);
      ab = ($urandom % 8) == 0;
      k = $urandom_range(1, 3);
      for (int b = 0; b < 2; b++) begin
        bus.icache_raddr_i = a + 32'(b * 8);
        bus.icache_rmask_i = 8'hFF;
        bus.icache_valid_i = 1'b1;
        exp_i.push_back(fdat(a + 32'(b * 8)));
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < (ab ? k : 400)) begin
          @(negedge clk);
          cyc++;
          done = bus.icache_ready_o;
        end
        @(posedge clk);
        #1;
        if (!ab) chk("icache_beat_done", 64'(done), 64'd1);
        if (!done) begin
          void'(exp_i.pop_back());
          break;
        end
      end
      bus.icache_valid_i = 1'b0;
    end
  endtask

  task automatic dcache_run(int n);
    logic [31:0] a;
    bit ab, done;
    int k, cyc;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      a = $urandom & 32'hFFFF_FFF8;
      ab = ($urandom % 8) == 0;
      k = $urandom_range(1, 3);
      bus.dcache_addr_i  = a;
      bus.dcache_wen_i   = 1'($urandom);
      bus.dcache_wdata_i = {$urandom, $urandom};
      bus.dcache_wmask_i = 8'($urandom);
      bus.dcache_rmask_i = 8'($urandom);
      bus.dcache_valid_i = 1'b1;
      exp_d.push_back(fdat(a));
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < (ab ? k : 400)) begin
        @(negedge clk);
        cyc++;
        done = bus.dcache_ready_o;
      end
      @(posedge clk);
      #1;
      if (!ab) chk("dcache_beat_done", 64'(done), 64'd1);
      if (!done) void'(exp_d.pop_back());
      bus.dcache_valid_i = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=still_running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.icache_raddr_i = '0; bus.icache_valid_i = 1'b0; bus.icache_rmask_i = '0;
    bus.dcache_addr_i = '0; bus.dcache_valid_i = 1'b0; bus.dcache_wen_i = 1'b0;
    bus.dcache_wdata_i = '0; bus.dcache_wmask_i = '0; bus.dcache_rmask_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_mem_valid", 64'(bus.mem_valid_o), 64'd0);
    // Simultaneous requests from idle, repeated; grant order reveals the tie rule.
    for (int r = 0; r < 4; r++) begin
      @(posedge clk);
      #1;
      bus.icache_raddr_i = 32'h8000_0010; bus.icache_rmask_i = 8'hFF; bus.icache_valid_i = 1'b1;
      bus.dcache_addr_i = 32'h1000_0020; bus.dcache_wen_i = 1'b1;
      bus.dcache_wdata_i = 64'hDEAD_BEEF; bus.dcache_wmask_i = 8'h0F; bus.dcache_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      w = (bus.mem_addr_o == 32'h1000_0020) ? 2 : (bus.mem_addr_o == 32'h8000_0010) ? 1 : 0;
      chk("tie_grant", 64'(w), 64'((RR && r % 2 == 1) ? 1 : 2));
      if (w == 2) begin
        chk("tie_wdata", bus.mem_wdata_o, 64'hDEAD_BEEF);
        chk("tie_wmask", 64'(bus.mem_wmask_o), 64'h0F);
      end
      @(posedge clk);
      #1;
      bus.icache_valid_i = 1'b0;
      bus.dcache_valid_i = 1'b0;
      bus.dcache_wen_i = 1'b0;
      repeat (2) @(posedge clk);
    end
    // Reset while an icache refill is waiting on memory.
    #1;
    bus.icache_raddr_i = 32'h8000_0010; bus.icache_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("refill_granted", 64'(bus.mem_valid_o), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_valid", 64'(bus.mem_valid_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.icache_valid_i = 1'b0;
    rdy_en = 1'b1; rdy_force = 1'b1; stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_icache_ready", 64'(bus.icache_ready_o), 64'd0);
      chk("stray_dcache_ready", 64'(bus.dcache_ready_o), 64'd0);
    end
    @(posedge clk);
    #1;
    rdy_force = 1'b0; stray = 1'b0;
    fork
      icache_run(60);
      dcache_run(80);
    join
    repeat (5) @(posedge clk);
    chk("icache_queue_drained", 64'(exp_i.size()), 64'd0);
    chk("dcache_queue_drained", 64'(exp_d.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
